lights_multi: RTL and testbench
===============================

LIGHTS_MULTI -- requirements
Module: lights_multi

Interface
REQ-001 Parameter N_CH, default 4, number of independent light channels (1..16).
REQ-002 Parameter CW, default 3, colour code width in bits (2..8).
REQ-003 Parameter PRESCALE, default 8, auto-step period in clk cycles (2..2^16).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset; all state clears while rst=0.
REQ-006 button  input  N_CH  per-channel step request, asynchronous to clk.
REQ-007 mode  input  2  step mode, shared by all channels: 00 hold, 01 prescaled hold, 10 press-edge, 11 treated as 00.
REQ-008 dir  input  1  step direction, shared: 0 up (+1), 1 down (-1).
REQ-009 lo  input  CW  lowest legal colour code, shared, quasi-static.
REQ-010 hi  input  CW  highest legal colour code, shared, quasi-static.
REQ-011 colour  output  N_CH*CW  packed colours; channel i occupies bits [i*CW +: CW].
REQ-012 wrap  output  N_CH  one-cycle pulse per channel on range wrap-around.

Function
REQ-013 Each button bit passes through a 2-flop synchroniser. A level sampled at edge k is visible as b_s at edge k+1 and acts on colour at edge k+2.
REQ-014 Mode 00: a channel steps once on every clk edge where its b_s=1.
REQ-015 Mode 01: a channel steps only on edges where its b_s=1 and tick=1.
- tick comes from a free-running shared counter 0..PRESCALE-1.
- tick=1 when count=PRESCALE-1, and the counter returns to 0 on the next edge.
REQ-016 Mode 10: a channel steps exactly once per 0->1 transition of its b_s; holding the button produces no further steps.
REQ-017 Step up: colour=hi goes to lo, otherwise colour+1. Step down: colour=lo goes to hi, otherwise colour-1.
REQ-018 No step: colour holds its value.
REQ-019 Out-of-range handling:
- If colour<lo or colour>hi at an edge, the next value is lo when dir=0 and hi when dir=1.
- This applies whether or not a step is requested.
- wrap stays 0 in this case.
REQ-020 If lo>hi, every channel is forced to lo on each edge, and wrap stays 0.
REQ-021 If lo=hi, colour stays at lo, and wrap pulses on each step request.
REQ-022 wrap[i]=1 for exactly the cycle following a hi->lo (up) or lo->hi (down) step of channel i; otherwise 0.
REQ-023 Channels are fully independent: simultaneous requests on several channels all take effect on the same edge.
REQ-024 A change of mode or dir takes effect on the next edge.
- The mode-10 edge detector keeps tracking b_s in all modes, so switching into mode 10 while a button is held does not cause a step.
REQ-025 All arithmetic is modulo 2^CW, used only inside [lo,hi]. No X may propagate to colour from any internal register after reset.

Reset
REQ-026 While rst=0, regardless of clk:
- colour of every channel = 1 (binary 0..01)
- wrap = 0
- synchronisers = 0
- edge-detect history = 0
- prescale counter = 0
REQ-027 Deassertion of rst is synchronised externally; the first step can occur no earlier than the second clk edge after rst rises.
REQ-028 A reset asserted mid-step or mid-prescale period aborts it. Nothing is remembered across reset.

Structure
REQ-029 Package lights_pkg holds the mode constants MODE_HOLD=2'b00, MODE_PRESC=2'b01, MODE_EDGE=2'b10, and the reset colour constant.
REQ-030 Sub-module lights_chan implements one channel:
- synchroniser, edge detect, step/wrap logic, colour and wrap registers
- instantiated N_CH times by a generate loop
REQ-031 The prescale counter lives once in lights_multi and fans tick out to all channels.

Verification
REQ-032 Reset and default range: rst=0 then 1, lo=1, hi=6, mode=00, dir=0, button[0] held high. Required response:
- channel 0 colour goes 1 after reset, then 2 at edge 3, and continues 2,3,4,5,6,1.
- wrap[0]=1 in the cycle after the 6->1 step.
- other channels stay at 1.
REQ-033 Prescaled mode: mode=01, PRESCALE=4, button[1] held. Required response: channel 1 advances exactly once every 4 cycles.
REQ-034 Press-edge mode: mode=10, button[2] gets three separate 10-cycle pulses. Required response: channel 2 advances exactly 3 steps, 1->4.
REQ-035 Down and out-of-range: dir=1, lo=2, hi=5, channel at 1. Required response:
- the next edge gives 5.
- stepping continues 4,3,2, then 5 with a wrap pulse.
REQ-036 Simultaneous requests and async reset: all buttons high for several cycles, then rst pulsed low between edges. Required response:
- all channels match while running.
- all colours read 1 immediately on the rst fall, with no clk edge.

Source files
------------

// File: rtl/lights_multi_pkg.sv
// -----------------------------------------------------------------------------
// lights_pkg
// Shared constants and helpers for the multi-channel colour stepper.
//   MODE_*        : encodings of the shared two-bit step mode input
//   RESET_COLOUR  : colour code every channel holds while reset is asserted
//   step_req()    : decodes mode + synchronised button state into a step request
// -----------------------------------------------------------------------------
package lights_pkg;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_PRESC = 2'b01;
    localparam logic [1:0] MODE_EDGE  = 2'b10;

    localparam int unsigned RESET_COLOUR = 32'd1;

    // Step request for one channel. The unused encoding 2'b11 falls into the
    // default branch and behaves exactly like hold mode.
    function automatic logic step_req(
        input logic [1:0] mode,
        input logic       b_s,
        input logic       b_prev,
        input logic       tick
    );
        logic req;
        case (mode)
            MODE_HOLD:  req = b_s;
            MODE_PRESC: req = b_s & tick;
            MODE_EDGE:  req = b_s & ~b_prev;
            default:    req = b_s;
        endcase
        return req;
    endfunction

endpackage

// File: rtl/lights_multi_if.sv
// -----------------------------------------------------------------------------
// lights_multi_if
// Bundles the shared control inputs and the per-channel outputs of lights_multi.
//   button : per-channel step request (asynchronous to clk)
//   mode   : shared step mode
//   dir    : shared direction, 0 up / 1 down
//   lo, hi : shared legal colour range, quasi-static
//   colour : packed colours, channel i at [i*CW +: CW]
//   wrap   : per-channel one-cycle wrap-around pulse
// master drives the controls (testbench / system), slave is the stepper.
// -----------------------------------------------------------------------------
interface lights_multi_if #(
    parameter int N_CH = 4,
    parameter int CW   = 3
);
    logic [N_CH-1:0]    button;
    logic [1:0]         mode;
    logic               dir;
    logic [CW-1:0]      lo;
    logic [CW-1:0]      hi;
    logic [N_CH*CW-1:0] colour;
    logic [N_CH-1:0]    wrap;

    modport master (
        output button, mode, dir, lo, hi,
        input  colour, wrap
    );

    modport slave (
        input  button, mode, dir, lo, hi,
        output colour, wrap
    );
endinterface

// File: rtl/lights_multi_chan.sv
// -----------------------------------------------------------------------------
// lights_chan
// One independent colour channel: button synchroniser, press-edge detector,
// range-checked up/down stepping, and registered colour / wrap outputs.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_button       : raw asynchronous step request for this channel
//   i_mode, i_dir  : shared step mode and direction
//   i_lo, i_hi     : shared legal colour range
//   i_tick         : shared prescaler tick (one cycle every PRESCALE)
//   o_colour       : current colour code (registered)
//   o_wrap         : pulses for the cycle after a range wrap-around (registered)
// -----------------------------------------------------------------------------
module lights_chan
    import lights_pkg::*;
#(
    parameter int CW = 3
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_button,
    input  logic [1:0]    i_mode,
    input  logic          i_dir,
    input  logic [CW-1:0] i_lo,
    input  logic [CW-1:0] i_hi,
    input  logic          i_tick,
    output logic [CW-1:0] o_colour,
    output logic          o_wrap
);

    localparam logic [CW-1:0] COLOUR_RST = CW'(RESET_COLOUR);

    logic          r_sync1;
    logic          r_sync2;      // synchronised button level (b_s)
    logic          r_prev;       // b_s one cycle earlier, for press-edge detect
    logic [CW-1:0] r_colour;
    logic          r_wrap;

    logic          w_req;
    logic [CW-1:0] w_colour_nxt;
    logic          w_wrap_nxt;

    // Two-flop synchroniser plus edge history; history tracks b_s in every
    // mode so entering press-edge mode with a held button does not step.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_button;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Step request decode for the current mode.
    always_comb begin
        w_req = step_req(i_mode, r_sync2, r_prev, i_tick);
    end

    // Next colour / wrap: an inverted range pins to lo, an out-of-range colour
    // snaps back into range without a wrap, otherwise a request steps with wrap.
    always_comb begin
        w_colour_nxt = r_colour;
        w_wrap_nxt   = 1'b0;
        if (i_lo > i_hi) begin
            w_colour_nxt = i_lo;
        end else if ((r_colour < i_lo) || (r_colour > i_hi)) begin
            w_colour_nxt = i_dir ? i_hi : i_lo;
        end else if (w_req) begin
            if (i_dir == 1'b0) begin
                if (r_colour == i_hi) begin
                    w_colour_nxt = i_lo;
                    w_wrap_nxt   = 1'b1;
                end else begin
                    w_colour_nxt = r_colour + CW'(1'b1);
                end
            end else begin
                if (r_colour == i_lo) begin
                    w_colour_nxt = i_hi;
                    w_wrap_nxt   = 1'b1;
                end else begin
                    w_colour_nxt = r_colour - CW'(1'b1);
                end
            end
        end else begin
            w_colour_nxt = r_colour;
        end
    end

    // Colour and wrap registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_colour <= COLOUR_RST;
            r_wrap   <= 1'b0;
        end else begin
            r_colour <= w_colour_nxt;
            r_wrap   <= w_wrap_nxt;
        end
    end

    assign o_colour = r_colour;
    assign o_wrap   = r_wrap;

endmodule

// File: rtl/lights_multi.sv
// -----------------------------------------------------------------------------
// lights_multi
// N_CH independent colour steppers sharing mode, direction, range and a single
// free-running prescaler.
//   clk  : clock, all state updates on its rising edge
//   rst  : asynchronous active-low reset
//   bus  : lights_multi_if.slave (button, mode, dir, lo, hi in; colour, wrap out)
// Parameters: N_CH channels (1..16), CW colour bits (2..8),
//             PRESCALE auto-step period in cycles (2..65536).
// -----------------------------------------------------------------------------
module lights_multi
    import lights_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int CW       = 3,
    parameter int PRESCALE = 8
) (
    input  logic           clk,
    input  logic           rst,
    lights_multi_if.slave  bus
);

    // Counter width: $clog2 of the period holds 0..PRESCALE-1; PRESCALE=2 needs 1 bit.
    localparam int             PW      = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  TICK_AT = PW'(PRESCALE - 1);

    logic [PW-1:0] r_cnt;
    logic          w_tick;
    logic [CW-1:0] w_colour [N_CH];
    logic [N_CH-1:0] w_wrap;

    assign w_tick = (r_cnt == TICK_AT);

    // Shared free-running prescaler, 0..PRESCALE-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PW'(1'b1);
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
        lights_chan #(
            .CW (CW)
        ) u_chan (
            .i_clk    (clk),
            .i_rst_n  (rst),
            .i_button (bus.button[gi]),
            .i_mode   (bus.mode),
            .i_dir    (bus.dir),
            .i_lo     (bus.lo),
            .i_hi     (bus.hi),
            .i_tick   (w_tick),
            .o_colour (w_colour[gi]),
            .o_wrap   (w_wrap[gi])
        );
    end

    // Pack the per-channel registered colours onto the shared output bus.
    always_comb begin
        bus.colour = '0;
        for (int i = 0; i < N_CH; i++) begin
            bus.colour[i*CW +: CW] = w_colour[i];
        end
        bus.wrap = w_wrap;
    end

endmodule

// File: tb/tb_lights_multi.sv
module tb_lights_multi;
    import lights_pkg::*;

    localparam int N_CH     = 4;
    localparam int CW       = 3;
    localparam int PRESCALE = 4;
    localparam int VW       = N_CH * CW;

    typedef struct packed {
        logic [VW-1:0]   col;
        logic [VW-1:0]   cm;
        logic [N_CH-1:0] w;
        logic [N_CH-1:0] wm;
    } exp_t;

    logic clk;
    logic rst;

    lights_multi_if #(.N_CH(N_CH), .CW(CW)) bus ();

    lights_multi #(
        .N_CH     (N_CH),
        .CW       (CW),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t  q_exp [$];
    string q_name [$];
    int    checks = 0;
    int    errors = 0;
    exp_t  mon_e;
    string mon_nm;

    int seq_up [10] = '{1, 1, 2, 3, 4, 5, 6, 1, 2, 3};
    int seq_dn [7]  = '{5, 5, 4, 3, 2, 5, 4};

    localparam logic [VW-1:0]   ALL_C = {VW{1'b1}};
    localparam logic [N_CH-1:0] ALL_W = {N_CH{1'b1}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [VW-1:0] pack4(input int c3, input int c2, input int c1, input int c0);
        return {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
    endfunction

    // Push expectation for the next rising edge, then advance to the next falling edge.
    task automatic cyc(input logic [VW-1:0] col, input logic [N_CH-1:0] w, input string name);
        exp_t e;
        e.col = col;
        e.cm  = ALL_C;
        e.w   = w;
        e.wm  = ALL_W;
        q_exp.push_back(e);
        q_name.push_back(name);
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.button = 4'b0000;
        rst        = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Monitor: compare DUT outputs shortly after each rising edge against the scoreboard.
    always @(posedge clk) begin
        #2;
        if (q_exp.size() > 0) begin
            mon_e  = q_exp.pop_front();
            mon_nm = q_name.pop_front();
            checks++;
            if ((((bus.colour ^ mon_e.col) & mon_e.cm) != '0) ||
                (((bus.wrap ^ mon_e.w) & mon_e.wm) != '0)) begin
                errors++;
                $display("FAIL %s colour=%h required=%h wrap=%b required=%b",
                         mon_nm, bus.colour, mon_e.col, bus.wrap, mon_e.w);
            end
        end
    end

    initial begin
        rst        = 1'b0;
        bus.button = 4'b0000;
        bus.mode   = MODE_HOLD;
        bus.dir    = 1'b0;
        bus.lo     = 3'd1;
        bus.hi     = 3'd6;
        @(negedge clk);

        // Reset state and hold-mode stepping up through a wrap on channel 0.
        cyc(pack4(1, 1, 1, 1), 4'b0000, "reset_state");
        cyc(pack4(1, 1, 1, 1), 4'b0000, "reset_state");
        rst        = 1'b1;
        bus.button = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            cyc(pack4(1, 1, 1, seq_up[i]), (i == 7) ? 4'b0001 : 4'b0000, "hold_up");
        end

        // Prescaled mode: channel 1 steps on every 4th edge.
        do_reset();
        bus.mode   = MODE_PRESC;
        bus.dir    = 1'b0;
        bus.lo     = 3'd1;
        bus.hi     = 3'd6;
        rst        = 1'b1;
        bus.button = 4'b0010;
        for (int e = 1; e <= 16; e++) begin
            cyc(pack4(1, 1, 1 + e / 4, 1), 4'b0000, "presc");
        end

        // Press-edge mode: three 10-cycle pulses give exactly three steps.
        do_reset();
        bus.mode   = MODE_EDGE;
        rst        = 1'b1;
        cyc(pack4(1, 1, 1, 1), 4'b0000, "edge_idle");
        cyc(pack4(1, 1, 1, 1), 4'b0000, "edge_idle");
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 15; c++) begin
                bus.button = (c < 10) ? 4'b0100 : 4'b0000;
                cyc(pack4(1, 1 + p + ((c >= 2) ? 1 : 0), 1, 1), 4'b0000, "edge");
            end
        end

        // Down direction from out-of-range colour 1 with range 2..5.
        do_reset();
        bus.mode   = MODE_HOLD;
        bus.dir    = 1'b1;
        bus.lo     = 3'd2;
        bus.hi     = 3'd5;
        rst        = 1'b1;
        bus.button = 4'b1000;
        for (int i = 0; i < 7; i++) begin
            cyc(pack4(seq_dn[i], 5, 5, 5), (i == 5) ? 4'b1000 : 4'b0000, "down_oor");
        end

        // lo == hi: colour pinned, wrap pulses on every request; then lo > hi.
        do_reset();
        bus.mode   = MODE_HOLD;
        bus.dir    = 1'b0;
        bus.lo     = 3'd3;
        bus.hi     = 3'd3;
        rst        = 1'b1;
        bus.button = 4'b0001;
        for (int e = 1; e <= 5; e++) begin
            cyc(pack4(3, 3, 3, 3), (e >= 3) ? 4'b0001 : 4'b0000, "lo_eq_hi");
        end
        bus.lo = 3'd5;
        bus.hi = 3'd2;
        for (int e = 0; e < 3; e++) begin
            cyc(pack4(5, 5, 5, 5), 4'b0000, "lo_gt_hi");
        end

        // All channels together, then asynchronous reset between edges.
        do_reset();
        bus.mode   = MODE_HOLD;
        bus.dir    = 1'b0;
        bus.lo     = 3'd1;
        bus.hi     = 3'd6;
        rst        = 1'b1;
        bus.button = 4'b1111;
        for (int e = 1; e <= 5; e++) begin
            cyc(pack4((e < 3) ? 1 : e - 1, (e < 3) ? 1 : e - 1,
                      (e < 3) ? 1 : e - 1, (e < 3) ? 1 : e - 1), 4'b0000, "all_chan");
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ((bus.colour != pack4(1, 1, 1, 1)) || (bus.wrap != 4'b0000)) begin
            errors++;
            $display("FAIL async_rst colour=%h required=%h wrap=%b required=%b",
                     bus.colour, pack4(1, 1, 1, 1), bus.wrap, 4'b0000);
        end
        @(negedge clk);
        rst = 1'b1;

        // Bounded drain of any outstanding expectations.
        for (int i = 0; i < 10; i++) begin
            if (q_exp.size() > 0) begin
                @(negedge clk);
            end
        end
        if (q_exp.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", q_exp.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
